// File: rtl/nonogram_session_ctrl_if.sv
// Purpose: shared line-FIFO write port between the session controller and the FIFO.
// Signals:
//   fifo_din   : muxed FIFO data word (LINE_W bits)
//   fifo_wr_en : muxed FIFO write enable
//   fifo_srst  : FIFO synchronous reset
//   fifo_full  : FIFO full flag (from FIFO)
// Modports: master = controller side, slave = FIFO side.
interface nonogram_session_ctrl_if #(
   parameter int unsigned LINE_W = 16
) ();
   logic [LINE_W-1:0] fifo_din;
   logic              fifo_wr_en;
   logic              fifo_srst;
   logic              fifo_full;

   modport master (output fifo_din, output fifo_wr_en, output fifo_srst, input fifo_full);
   modport slave  (input fifo_din, input fifo_wr_en, input fifo_srst, output fifo_full);
endinterface

// File: rtl/nonogram_session_ctrl.sv
// Purpose: sequences one nonogram board at a time through receive, solve and
// transmit; muxes the line FIFO write port, latches board dimensions, checks
// dimensions, runs a solve watchdog, reports failures with a one-byte UART code,
// supports abort and keeps saturating session statistics.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   abort                         : abandon current board
//   receive_done, received_data   : UART rx byte strobe / data
//   parsed, parse_write, parse_line, m_in, n_in : parser interface
//   solve_write, solve_line, solved, unsolvable : solver interface
//   assembled, transmit_done      : assembler done / UART tx byte finished
//   fifo                          : FIFO write port (interface, master side)
//   solver_start, num_rows, num_cols : solver kick-off and latched dimensions
//   fail_send, fail_byte          : failure byte tx request and code
//   state_out, display_value      : status
//   boards_ok, boards_failed      : saturating session counters
module nonogram_session_ctrl #(
   parameter int unsigned MAX_ROWS       = 11,
   parameter int unsigned MAX_COLS       = 11,
   parameter int unsigned LINE_W         = 16,
   parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
   parameter int unsigned STAT_W         = 8
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              abort,
   input  logic                              receive_done,
   input  logic [7:0]                        received_data,
   input  logic                              parsed,
   input  logic                              parse_write,
   input  logic [LINE_W-1:0]                 parse_line,
   input  logic [$clog2(MAX_ROWS+1)-1:0]     m_in,
   input  logic [$clog2(MAX_COLS+1)-1:0]     n_in,
   input  logic                              solve_write,
   input  logic [LINE_W-1:0]                 solve_line,
   input  logic                              solved,
   input  logic                              unsolvable,
   input  logic                              assembled,
   input  logic                              transmit_done,
   nonogram_session_ctrl_if.master           fifo,
   output logic                              solver_start,
   output logic [$clog2(MAX_ROWS+1)-1:0]     num_rows,
   output logic [$clog2(MAX_COLS+1)-1:0]     num_cols,
   output logic                              fail_send,
   output logic [7:0]                        fail_byte,
   output logic [2:0]                        state_out,
   output logic [7:0]                        display_value,
   output logic [STAT_W-1:0]                 boards_ok,
   output logic [STAT_W-1:0]                 boards_failed
);
   localparam int unsigned RW   = $clog2(MAX_ROWS + 1);
   localparam int unsigned CW   = $clog2(MAX_COLS + 1);
   localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES);

   localparam logic [7:0] CODE_OVERFLOW = 8'hEC;
   localparam logic [7:0] CODE_DIMS     = 8'hED;
   localparam logic [7:0] CODE_UNSOLV   = 8'hEE;
   localparam logic [7:0] CODE_TIMEOUT  = 8'hEF;

   typedef enum logic [2:0] {
      S_RECEIVE   = 3'd0,
      S_SOLVE     = 3'd1,
      S_TRANSMIT  = 3'd2,
      S_FAIL_SEND = 3'd3,
      S_FAIL_WAIT = 3'd4
   } state_t;

   state_t            state;
   logic              fifo_rst_q;
   logic [WD_W-1:0]   wd_cnt;

   logic [LINE_W-1:0] din_c;
   logic              wr_en_c;
   logic              overflow_c;
   logic              dims_bad_c;
   logic              wd_expired_c;
   logic              fail_req_c;
   logic [7:0]        fail_code_c;

   // FIFO write-port mux: parser owns it while receiving, solver while solving
   always_comb begin
      din_c   = '0;
      wr_en_c = 1'b0;
      case (state)
         S_RECEIVE: begin
            din_c   = parse_line;
            wr_en_c = parse_write;
         end
         S_SOLVE: begin
            din_c   = solve_line;
            wr_en_c = solve_write;
         end
         default: ;
      endcase
   end

   assign fifo.fifo_din   = din_c;
   assign fifo.fifo_wr_en = wr_en_c;
   assign fifo.fifo_srst  = rst | fifo_rst_q;

   assign overflow_c   = wr_en_c & fifo.fifo_full;
   assign dims_bad_c   = (m_in == '0) || (m_in > RW'(MAX_ROWS)) ||
                         (n_in == '0) || (n_in > CW'(MAX_COLS));
   assign wd_expired_c = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

   // Failure detection; solved outranks every failure source in SOLVE
   always_comb begin
      fail_req_c  = 1'b0;
      fail_code_c = 8'h00;
      case (state)
         S_RECEIVE: begin
            if (overflow_c) begin
               fail_req_c  = 1'b1;
               fail_code_c = CODE_OVERFLOW;
            end else if (parsed && dims_bad_c) begin
               fail_req_c  = 1'b1;
               fail_code_c = CODE_DIMS;
            end
         end
         S_SOLVE: begin
            if (solved) begin
               fail_req_c = 1'b0;
            end else if (unsolvable) begin
               fail_req_c  = 1'b1;
               fail_code_c = CODE_UNSOLV;
            end else if (overflow_c) begin
               fail_req_c  = 1'b1;
               fail_code_c = CODE_OVERFLOW;
            end else if (wd_expired_c) begin
               fail_req_c  = 1'b1;
               fail_code_c = CODE_TIMEOUT;
            end
         end
         default: ;
      endcase
   end

   assign state_out = state;

   // Session FSM with registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_RECEIVE;
         fifo_rst_q    <= 1'b0;
         wd_cnt        <= '0;
         solver_start  <= 1'b0;
         num_rows      <= '0;
         num_cols      <= '0;
         fail_send     <= 1'b0;
         fail_byte     <= 8'h00;
         display_value <= 8'h00;
         boards_ok     <= '0;
         boards_failed <= '0;
      end else begin
         fifo_rst_q   <= 1'b0;
         solver_start <= 1'b0;
         fail_send    <= 1'b0;

         // Solution bytes are not visible here, so only failure bytes echo on tx
         if (receive_done)
            display_value <= received_data;
         else if (transmit_done && state == S_FAIL_WAIT)
            display_value <= fail_byte;

         if (!abort && state == S_RECEIVE && parsed) begin
            num_rows <= m_in;
            num_cols <= n_in;
         end

         if (abort) begin
            state      <= S_RECEIVE;
            fifo_rst_q <= 1'b1;
         end else if (fail_req_c) begin
            // fail_send is raised on entry so it is high exactly during FAIL_SEND
            state      <= S_FAIL_SEND;
            fail_byte  <= fail_code_c;
            fail_send  <= 1'b1;
            fifo_rst_q <= 1'b1;
         end else begin
            case (state)
               S_RECEIVE: begin
                  if (parsed) begin
                     state        <= S_SOLVE;
                     solver_start <= 1'b1;
                     wd_cnt       <= '0;
                  end
               end
               S_SOLVE: begin
                  if (solved) begin
                     state      <= S_TRANSMIT;
                     fifo_rst_q <= 1'b1;
                  end else begin
                     wd_cnt <= wd_cnt + WD_W'(1);
                  end
               end
               S_TRANSMIT: begin
                  if (assembled) begin
                     state <= S_RECEIVE;
                     if (boards_ok != '1)
                        boards_ok <= boards_ok + STAT_W'(1);
                  end
               end
               S_FAIL_SEND: begin
                  state <= S_FAIL_WAIT;
                  if (boards_failed != '1)
                     boards_failed <= boards_failed + STAT_W'(1);
               end
               S_FAIL_WAIT: begin
                  if (transmit_done)
                     state <= S_RECEIVE;
               end
               default: state <= S_RECEIVE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_nonogram_session_ctrl.sv
// Purpose: directed self-checking bench for nonogram_session_ctrl
// (MAX 11x11, LINE_W 16, TIMEOUT_CYCLES 100, STAT_W 8).
module tb_nonogram_session_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic        abort;
   logic        receive_done;
   logic [7:0]  received_data;
   logic        parsed;
   logic        parse_write;
   logic [15:0] parse_line;
   logic [3:0]  m_in;
   logic [3:0]  n_in;
   logic        solve_write;
   logic [15:0] solve_line;
   logic        solved;
   logic        unsolvable;
   logic        assembled;
   logic        transmit_done;
   logic        solver_start;
   logic [3:0]  num_rows;
   logic [3:0]  num_cols;
   logic        fail_send;
   logic [7:0]  fail_byte;
   logic [2:0]  state_out;
   logic [7:0]  display_value;
   logic [7:0]  boards_ok;
   logic [7:0]  boards_failed;

   int checks = 0;
   int errors = 0;
   int fs_cnt = 0;

   nonogram_session_ctrl_if #(.LINE_W(16)) fifo_bus ();

   nonogram_session_ctrl #(
      .MAX_ROWS(11), .MAX_COLS(11), .LINE_W(16), .TIMEOUT_CYCLES(100), .STAT_W(8)
   ) dut (
      .clk(clk), .rst(rst), .abort(abort),
      .receive_done(receive_done), .received_data(received_data),
      .parsed(parsed), .parse_write(parse_write), .parse_line(parse_line),
      .m_in(m_in), .n_in(n_in),
      .solve_write(solve_write), .solve_line(solve_line),
      .solved(solved), .unsolvable(unsolvable), .assembled(assembled),
      .transmit_done(transmit_done), .fifo(fifo_bus),
      .solver_start(solver_start), .num_rows(num_rows), .num_cols(num_cols),
      .fail_send(fail_send), .fail_byte(fail_byte), .state_out(state_out),
      .display_value(display_value), .boards_ok(boards_ok),
      .boards_failed(boards_failed)
   );

   always #5 clk = ~clk;

   // Count cycles with fail_send high, sampled mid-cycle
   always @(negedge clk) if (fail_send === 1'b1) fs_cnt++;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      int fs_base;
      rst = 1'b1; abort = 0; receive_done = 0; received_data = 0; parsed = 0;
      parse_write = 0; parse_line = 0; m_in = 0; n_in = 0; solve_write = 0;
      solve_line = 0; solved = 0; unsolvable = 0; assembled = 0;
      transmit_done = 0; fifo_bus.fifo_full = 0;
      tick(); tick();
      chk("srst_in_reset", 32'(fifo_bus.fifo_srst), 1);
      rst = 1'b0;
      tick();
      chk("rst_state", 32'(state_out), 0);
      chk("rst_srst", 32'(fifo_bus.fifo_srst), 0);
      chk("rst_ok", 32'(boards_ok), 0);
      chk("rst_failed", 32'(boards_failed), 0);
      chk("rst_fail_byte", 32'(fail_byte), 0);
      chk("rst_start", 32'(solver_start), 0);

      // Good 5x5 board
      parse_write = 1; parse_line = 16'hA5A5; #1;
      chk("rx_wr_en", 32'(fifo_bus.fifo_wr_en), 1);
      chk("rx_din", 32'(fifo_bus.fifo_din), 32'h0000A5A5);
      parse_write = 0;
      parsed = 1; m_in = 5; n_in = 5;
      tick();
      parsed = 0;
      chk("good_state_solve", 32'(state_out), 1);
      chk("good_start", 32'(solver_start), 1);
      chk("good_rows", 32'(num_rows), 5);
      chk("good_cols", 32'(num_cols), 5);
      tick();
      chk("good_start_off", 32'(solver_start), 0);
      solve_write = 1; solve_line = 16'h1234; #1;
      chk("solve_wr_en", 32'(fifo_bus.fifo_wr_en), 1);
      chk("solve_din", 32'(fifo_bus.fifo_din), 32'h00001234);
      solve_write = 0;
      solved = 1;
      tick();
      solved = 0;
      chk("good_state_tx", 32'(state_out), 2);
      chk("good_srst", 32'(fifo_bus.fifo_srst), 1);
      tick();
      chk("good_srst_off", 32'(fifo_bus.fifo_srst), 0);
      parse_write = 1; #1;
      chk("tx_wr_en_blocked", 32'(fifo_bus.fifo_wr_en), 0);
      chk("tx_din_zero", 32'(fifo_bus.fifo_din), 0);
      parse_write = 0;
      assembled = 1;
      tick();
      assembled = 0;
      chk("good_back_rx", 32'(state_out), 0);
      chk("good_ok", 32'(boards_ok), 1);

      // Bad dimensions 12x5
      fs_base = fs_cnt;
      parsed = 1; m_in = 12; n_in = 5;
      tick();
      parsed = 0;
      chk("dims_state", 32'(state_out), 3);
      chk("dims_fail_send", 32'(fail_send), 1);
      chk("dims_code", 32'(fail_byte), 32'hED);
      chk("dims_no_start", 32'(solver_start), 0);
      chk("dims_rows_latched", 32'(num_rows), 12);
      chk("dims_srst", 32'(fifo_bus.fifo_srst), 1);
      tick();
      chk("dims_wait", 32'(state_out), 4);
      chk("dims_fail_send_off", 32'(fail_send), 0);
      chk("dims_failed_cnt", 32'(boards_failed), 1);
      transmit_done = 1;
      tick();
      transmit_done = 0;
      chk("dims_back_rx", 32'(state_out), 0);
      chk("dims_display", 32'(display_value), 32'hED);
      chk("dims_one_pulse", 32'(fs_cnt - fs_base), 1);
      receive_done = 1; received_data = 8'h3C;
      tick();
      receive_done = 0;
      chk("rx_display", 32'(display_value), 32'h3C);

      // Watchdog
      fs_base = fs_cnt;
      parsed = 1; m_in = 3; n_in = 4;
      tick();
      parsed = 0;
      for (int i = 0; i < 99; i++) tick();
      chk("wd_still_solve", 32'(state_out), 1);
      chk("wd_no_fail_yet", 32'(fs_cnt - fs_base), 0);
      tick();
      chk("wd_state", 32'(state_out), 3);
      chk("wd_code", 32'(fail_byte), 32'hEF);
      chk("wd_srst", 32'(fifo_bus.fifo_srst), 1);
      tick();
      chk("wd_failed_cnt", 32'(boards_failed), 2);
      tick(); tick();
      chk("wd_one_pulse", 32'(fs_cnt - fs_base), 1);
      transmit_done = 1;
      tick();
      transmit_done = 0;

      // solved and unsolvable together
      fs_base = fs_cnt;
      parsed = 1; m_in = 5; n_in = 5;
      tick();
      parsed = 0;
      solved = 1; unsolvable = 1;
      tick();
      solved = 0; unsolvable = 0;
      chk("both_state_tx", 32'(state_out), 2);
      tick();
      chk("both_no_fail", 32'(fs_cnt - fs_base), 0);
      chk("both_failed_same", 32'(boards_failed), 2);
      assembled = 1;
      tick();
      assembled = 0;
      chk("both_ok", 32'(boards_ok), 2);

      // Overflow in SOLVE
      parsed = 1; m_in = 2; n_in = 2;
      tick();
      parsed = 0;
      solve_write = 1; fifo_bus.fifo_full = 1;
      tick();
      solve_write = 0; fifo_bus.fifo_full = 0;
      chk("ovf_state", 32'(state_out), 3);
      chk("ovf_code", 32'(fail_byte), 32'hEC);
      tick();
      transmit_done = 1;
      tick();
      transmit_done = 0;
      chk("ovf_failed_cnt", 32'(boards_failed), 3);

      // Abort at solve cycle 40
      fs_base = fs_cnt;
      parsed = 1; m_in = 7; n_in = 6;
      tick();
      parsed = 0;
      for (int i = 0; i < 39; i++) tick();
      abort = 1;
      tick();
      abort = 0;
      chk("abort_state", 32'(state_out), 0);
      chk("abort_srst", 32'(fifo_bus.fifo_srst), 1);
      tick();
      chk("abort_srst_off", 32'(fifo_bus.fifo_srst), 0);
      chk("abort_no_fail", 32'(fs_cnt - fs_base), 0);
      chk("abort_failed_same", 32'(boards_failed), 3);
      chk("abort_rows_kept", 32'(num_rows), 7);

      // Events ignored outside their state
      solved = 1; assembled = 1;
      tick();
      solved = 0; assembled = 0;
      chk("ignore_state", 32'(state_out), 0);
      chk("ignore_ok", 32'(boards_ok), 2);

      // 256 forced failures saturate the counter
      for (int i = 0; i < 256; i++) begin
         parsed = 1; m_in = 0; n_in = 3;
         tick();
         parsed = 0;
         tick();
         transmit_done = 1;
         tick();
         transmit_done = 0;
      end
      chk("sat_failed", 32'(boards_failed), 255);
      chk("sat_code_zero_dim", 32'(fail_byte), 32'hED);
      chk("sat_ok_same", 32'(boards_ok), 2);

      // Reset mid-operation
      parsed = 1; m_in = 5; n_in = 5;
      tick();
      parsed = 0;
      rst = 1;
      tick();
      chk("mid_rst_srst", 32'(fifo_bus.fifo_srst), 1);
      chk("mid_rst_state", 32'(state_out), 0);
      chk("mid_rst_failed", 32'(boards_failed), 0);
      chk("mid_rst_ok", 32'(boards_ok), 0);
      chk("mid_rst_rows", 32'(num_rows), 0);
      chk("mid_rst_fail_byte", 32'(fail_byte), 0);
      rst = 0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
